// File: rtl/muldiv_issue.sv
// Execute-stage issuer for the RV32M multiply/divide unit: latches one M-op, launches the unit,
// waits for completion (with a watchdog) and hands the result to writeback.
module muldiv_issue #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [4:0]  req_rd,
    input  logic        flush,
    output logic        stall,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [4:0]  res_rd,
    output logic        err,
    output logic        mu_start,
    output logic [31:0] mu_in_A,
    output logic [31:0] mu_in_B,
    output logic [1:0]  mu_op_mul,
    output logic [1:0]  mu_op_div,
    output logic        mu_sel,
    input  logic [31:0] mu_R,
    input  logic        mu_done
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, DONE} state_t;

    state_t      state_reg;
    logic        kill_reg;
    logic [7:0]  count_reg;
    logic [2:0]  funct3_reg;
    logic [4:0]  rd_reg;
    logic        accept;
    logic        kill_now;

    assign accept   = req_valid && req_ready && !flush;
    assign kill_now = kill_reg || flush;
    assign stall    = (state_reg != IDLE) || accept;

    // Unit controls come only from the latched request so they hold until the op ends.
    assign mu_sel    = funct3_reg[2];
    assign mu_op_mul = funct3_reg[1:0];
    assign mu_op_div = funct3_reg[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            kill_reg   <= 1'b0;
            count_reg  <= 8'd0;
            funct3_reg <= 3'd0;
            rd_reg     <= 5'd0;
            req_ready  <= 1'b1;
            res_valid  <= 1'b0;
            res_data   <= 32'd0;
            res_rd     <= 5'd0;
            err        <= 1'b0;
            mu_start   <= 1'b0;
            mu_in_A    <= 32'd0;
            mu_in_B    <= 32'd0;
        end else begin
            err      <= 1'b0;
            mu_start <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        funct3_reg <= req_funct3;
                        mu_in_A    <= req_rs1;
                        mu_in_B    <= req_rs2;
                        rd_reg     <= req_rd;
                        count_reg  <= 8'd0;
                        mu_start   <= 1'b1;
                        req_ready  <= 1'b0;
                        state_reg  <= LAUNCH;
                    end
                end
                LAUNCH, BUSY: begin
                    if (flush) kill_reg <= 1'b1;
                    if (mu_done) begin
                        res_data <= mu_R;
                        res_rd   <= rd_reg;
                        if (kill_now) begin
                            // Killed op: drain the unit silently, never show DONE.
                            kill_reg  <= 1'b0;
                            req_ready <= 1'b1;
                            state_reg <= IDLE;
                        end else begin
                            res_valid <= 1'b1;
                            state_reg <= DONE;
                        end
                    end else if (state_reg == LAUNCH) begin
                        count_reg <= 8'd0;
                        state_reg <= BUSY;
                    end else if (count_reg == TIMEOUT_CNT) begin
                        err       <= 1'b1;
                        kill_reg  <= 1'b0;
                        req_ready <= 1'b1;
                        state_reg <= IDLE;
                    end else begin
                        count_reg <= count_reg + 8'd1;
                    end
                end
                DONE: begin
                    if (res_ready || flush) begin
                        res_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/muldiv_issue.md
# muldiv_issue

Pipeline-side issuer for the RV32M multiply/divide unit. It sits in the execute stage. It accepts one M-extension operation at a time from the pipeline and decodes funct3 into the unit's op_mul/op_div/muldiv_sel controls. It drives the unit's start/operands until muldiv_done, then captures R and presents it to writeback with a valid/ready handshake. It also owns pipeline stall, flush-kill and a completion watchdog.

## Interface
- TIMEOUT, 64: cycles after start without muldiv_done before the op is abandoned; range 2..255.
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  pipeline presents an M-op
- req_ready  out  1  issuer can accept (high only in IDLE)
- req_funct3  in  3  RV32M funct3
- req_rs1, req_rs2  in  32  operands
- req_rd  in  5  destination register
- flush  in  1  kill in-flight/pending op
- stall  out  1  hold earlier pipeline stages
- res_valid  out  1  result available
- res_ready  in  1  writeback accepts result
- res_data  out  32  result
- res_rd  out  5  destination of result
- err  out  1  one-cycle pulse on watchdog expiry
- mu_start  out  1  to unit start
- mu_in_A, mu_in_B  out  32  to unit operands
- mu_op_mul, mu_op_div  out  2  to unit op selects
- mu_sel  out  1  to unit muldiv_sel (1 = divide)
- mu_R  in  32  unit result
- mu_done  in  1  unit completion

## Operation
- Decode: mu_sel = funct3[2]; mu_op_mul = mu_op_div = funct3[1:0].
  - Multiply: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
  - Divide: bit0 = unsigned, bit1 = remainder (DIV, DIVU, REM, REMU).
- Request latch: on req_valid && req_ready && !flush, latch funct3, rs1, rs2 and rd. mu_in_A, mu_in_B, mu_op_* and mu_sel are driven only from the latches and stay stable until the op ends, because the unit reads operand sign bits at output time.
- States: IDLE, LAUNCH, BUSY, DONE.
  - IDLE → LAUNCH on accept.
  - LAUNCH: mu_start = 1 for exactly this one cycle. Go to DONE if mu_done is high this cycle, else go to BUSY.
  - BUSY: go to DONE on mu_done.
  - DONE: go to IDLE when res_ready is high.
- Result capture: on the mu_done cycle, mu_R goes into res_data and latched rd goes into res_rd. Both stay stable while res_valid is high.
- res_valid = (state == DONE) && !kill.
- Flush:
  - Flush in IDLE blocks acceptance that cycle.
  - Flush in LAUNCH/BUSY sets kill. The unit cannot be aborted, so the FSM still waits for mu_done, then returns to IDLE from the done cycle without entering a visible DONE. res_valid never rises for that op.
  - Flush in DONE drops the result; go to IDLE next cycle.
  - kill clears on return to IDLE.
- Watchdog: an 8-bit counter clears at LAUNCH and increments each cycle in BUSY. When it reaches TIMEOUT with no mu_done, pulse err for one cycle, go to IDLE and discard the op. A later stray mu_done in IDLE is ignored.
- stall = (state != IDLE) || (req_valid && req_ready && !flush).
- mu_done outside LAUNCH/BUSY is ignored.

## Timing
- Reset values:
  - state = IDLE.
  - req_ready = 1.
  - stall, res_valid, err, mu_start, kill and counter = 0.
  - res_data, res_rd, mu_in_A, mu_in_B, mu_op_*, mu_sel = 0.
- Accept at cycle t; mu_start high at t+1.
- If mu_done is first seen at cycle d ≥ t+1, res_valid is high from d+1.
- Minimum accept-to-res_valid is 2 cycles (mu_done seen in LAUNCH).
- Back-to-back throughput: the next accept is possible at the cycle after the res_valid && res_ready handshake.
- Reset asserted mid-op forces IDLE immediately. The unit is reset by the same signal.

## Test plan
- MUL, rs1 = 7, rs2 = 0xFFFFFFFD, real unit → mu_start exactly one pulse; res_data = 0xFFFFFFEB, res_rd = req_rd; stall high from accept to the handshake.
- DIVU 100 / 7, then REM 0xFFFFFFF9 % 2 back-to-back → 0x0000000E, then 0xFFFFFFFF; second req_ready only after the first handshake.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF with res_ready held low 3 cycles → res_valid and res_data = 0xFFFFFFFE stable throughout; one handshake.
- DIV issued, flush two cycles after accept → res_valid never rises; idle (req_ready = 1) the cycle after mu_done.
- Stub unit that never asserts mu_done, TIMEOUT = 8 → err pulses once at counter = 8; state IDLE next cycle; a later injected mu_done is ignored.
- Reset pulsed low in BUSY → all outputs at reset values within the same cycle; a fresh MUL 3 × 5 afterwards returns 15.
